// File: rtl/csr_trap_seq_if.sv
// rtl/csr_trap_seq_if.sv - CSR register-file bus between the trap sequencer and the CSR file
interface csr_trap_seq_if;
  logic [31:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic        csr_re;
  logic [31:0] csr_rdata;
  logic        en_except;

  modport master (
    output csr_addr, csr_wdata, csr_we, csr_re, en_except,
    input  csr_rdata
  );

  modport slave (
    input  csr_addr, csr_wdata, csr_we, csr_re, en_except,
    output csr_rdata
  );
endinterface

// File: rtl/csr_trap_seq.sv
// rtl/csr_trap_seq.sv - machine-mode trap entry / MRET sequencer driving the CSR register file
module csr_trap_seq #(
  parameter logic [1:0] MPP_VAL = 2'b11,
  parameter bit         VEC_EN  = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           trap_req_i,
  input  logic [31:0]    trap_cause_i,
  input  logic [31:0]    trap_pc_i,
  input  logic           mret_req_i,
  output logic           trap_ack_o,
  output logic           mret_ack_o,
  output logic           redirect_valid_o,
  output logic [31:0]    redirect_pc_o,
  output logic           busy_o,
  csr_trap_seq_if.master csr
);

  localparam logic [31:0] A_MSTATUS = 32'h300;
  localparam logic [31:0] A_MTVEC   = 32'h305;
  localparam logic [31:0] A_MEPC    = 32'h341;
  localparam logic [31:0] A_MCAUSE  = 32'h342;

  typedef enum logic [3:0] {
    IDLE, T_WEPC, T_WCAUSE, T_RSTAT, T_WAITSTAT, T_WSTAT, T_RVEC, T_WAITVEC, T_REDIR,
    M_REPC, M_WAITEPC, M_RSTAT, M_WAITSTAT, M_WSTAT, M_REDIR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cause_q, pc_q, mstatus_q, mtvec_q, mepc_q;
  logic        vec_hit;
  logic [31:0] trap_target, trap_mstatus, mret_mstatus;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (trap_req_i)      state_d = T_WEPC;
        else if (mret_req_i) state_d = M_REPC;
      end
      T_WEPC:     state_d = T_WCAUSE;
      T_WCAUSE:   state_d = T_RSTAT;
      T_RSTAT:    state_d = T_WAITSTAT;
      T_WAITSTAT: state_d = T_WSTAT;
      T_WSTAT:    state_d = T_RVEC;
      T_RVEC:     state_d = T_WAITVEC;
      T_WAITVEC:  state_d = T_REDIR;
      T_REDIR:    state_d = IDLE;
      M_REPC:     state_d = M_WAITEPC;
      M_WAITEPC:  state_d = M_RSTAT;
      M_RSTAT:    state_d = M_WAITSTAT;
      M_WAITSTAT: state_d = M_WSTAT;
      M_WSTAT:    state_d = M_REDIR;
      M_REDIR:    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Read data arrives the cycle after csr_re, i.e. in the WAIT* states.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cause_q   <= '0;
      pc_q      <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
    end else begin
      if (state_q == IDLE && trap_req_i) begin
        cause_q <= trap_cause_i;
        pc_q    <= trap_pc_i;
      end
      if (state_q == T_WAITSTAT || state_q == M_WAITSTAT) mstatus_q <= csr.csr_rdata;
      if (state_q == T_WAITVEC) mtvec_q <= csr.csr_rdata;
      if (state_q == M_WAITEPC) mepc_q  <= csr.csr_rdata;
    end
  end

  // Vectored offset is cause[30:0]<<2 truncated to 32 bits, so only cause[29:0] survives.
  assign vec_hit      = VEC_EN && (mtvec_q[1:0] == 2'b01) && cause_q[31];
  assign trap_target  = (mtvec_q & 32'hFFFF_FFFC) + (vec_hit ? {cause_q[29:0], 2'b00} : 32'h0);
  assign trap_mstatus = {mstatus_q[31:13], MPP_VAL, mstatus_q[10:8], mstatus_q[3],
                         mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
  assign mret_mstatus = {mstatus_q[31:13], 2'b00, mstatus_q[10:8], 1'b1,
                         mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};
  assign busy_o       = (state_q != IDLE);

  always_comb begin
    trap_ack_o       = 1'b0;
    mret_ack_o       = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'h0;
    csr.csr_addr     = 32'h0;
    csr.csr_wdata    = 32'h0;
    csr.csr_we       = 1'b0;
    csr.csr_re       = 1'b0;
    csr.en_except    = 1'b0;
    unique case (state_q)
      IDLE: begin
        trap_ack_o = trap_req_i & ~rst_i;
        mret_ack_o = mret_req_i & ~trap_req_i & ~rst_i;
      end
      T_WEPC:   begin csr.csr_we = 1'b1; csr.csr_addr = A_MEPC;    csr.csr_wdata = pc_q & 32'hFFFF_FFFC; end
      T_WCAUSE: begin csr.csr_we = 1'b1; csr.csr_addr = A_MCAUSE;  csr.csr_wdata = cause_q; end
      T_RSTAT:  begin csr.csr_re = 1'b1; csr.csr_addr = A_MSTATUS; end
      T_WSTAT:  begin csr.csr_we = 1'b1; csr.csr_addr = A_MSTATUS; csr.csr_wdata = trap_mstatus; end
      T_RVEC:   begin csr.csr_re = 1'b1; csr.csr_addr = A_MTVEC;   csr.en_except = 1'b1; end
      T_WAITVEC: csr.en_except = 1'b1;
      T_REDIR: begin
        csr.en_except    = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = trap_target;
      end
      M_REPC:   begin csr.csr_re = 1'b1; csr.csr_addr = A_MEPC;    end
      M_RSTAT:  begin csr.csr_re = 1'b1; csr.csr_addr = A_MSTATUS; end
      M_WSTAT:  begin csr.csr_we = 1'b1; csr.csr_addr = A_MSTATUS; csr.csr_wdata = mret_mstatus; end
      M_REDIR: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mepc_q & 32'hFFFF_FFFC;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// tb/tb_csr_trap_seq.sv - randomized self-checking bench for csr_trap_seq against a CSR-file model
module tb_csr_trap_seq;
  localparam logic [1:0] MPP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        trap_req, mret_req;
  logic [31:0] trap_cause, trap_pc;
  logic        trap_ack, mret_ack, redir_valid, busy;
  logic [31:0] redir_pc_w;
  logic        nv_trap_ack, nv_mret_ack, nv_redir_valid, nv_busy;
  logic [31:0] nv_redir_pc;

  csr_trap_seq_if bus();
  csr_trap_seq_if bus_nv();

  always #5 clk = ~clk;

  csr_trap_seq #(.MPP_VAL(MPP), .VEC_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .trap_req_i(trap_req), .trap_cause_i(trap_cause),
    .trap_pc_i(trap_pc), .mret_req_i(mret_req), .trap_ack_o(trap_ack), .mret_ack_o(mret_ack),
    .redirect_valid_o(redir_valid), .redirect_pc_o(redir_pc_w), .busy_o(busy), .csr(bus.master)
  );

  csr_trap_seq #(.MPP_VAL(MPP), .VEC_EN(1'b0)) u_dut_nv (
    .clk_i(clk), .rst_i(rst_i), .trap_req_i(trap_req), .trap_cause_i(trap_cause),
    .trap_pc_i(trap_pc), .mret_req_i(mret_req), .trap_ack_o(nv_trap_ack), .mret_ack_o(nv_mret_ack),
    .redirect_valid_o(nv_redir_valid), .redirect_pc_o(nv_redir_pc), .busy_o(nv_busy), .csr(bus_nv.master)
  );

  // The no-vector instance issues the same reads at the same times, so it shares read data.
  assign bus_nv.csr_rdata = bus.csr_rdata;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [31:0] m_mepc, m_mcause, m_mstatus, m_mtvec;
  logic [31:0] pl_mepc = 0, pl_mstatus = 0, pl_mtvec = 0;
  logic        pl_go = 1'b0;
  int          wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_go) begin
      m_mepc <= pl_mepc; m_mstatus <= pl_mstatus; m_mtvec <= pl_mtvec; m_mcause <= 32'h0;
    end else if (bus.csr_we) begin
      wr_cnt <= wr_cnt + 1;
      case (bus.csr_addr)
        32'h341: m_mepc    <= bus.csr_wdata;
        32'h342: m_mcause  <= bus.csr_wdata;
        32'h300: m_mstatus <= bus.csr_wdata;
        32'h305: m_mtvec   <= bus.csr_wdata;
        default: ;
      endcase
    end
    if (bus.csr_re) begin
      case (bus.csr_addr)
        32'h341: bus.csr_rdata <= m_mepc;
        32'h342: bus.csr_rdata <= m_mcause;
        32'h300: bus.csr_rdata <= m_mstatus;
        32'h305: bus.csr_rdata <= m_mtvec;
        default: bus.csr_rdata <= 32'hDEAD_BEEF;
      endcase
    end else begin
      bus.csr_rdata <= $urandom;
    end
  end

  int tack_cnt = 0, mack_cnt = 0, redir_cnt = 0, en_cnt = 0;
  int tack_cyc = 0, mack_cyc = 0, redir_cyc = 0;
  int both_cnt = 0, leak_cnt = 0, dual_cnt = 0;
  logic [31:0] redir_pc = 0, nv_pc = 0;

  always @(negedge clk) begin
    if (trap_ack) begin tack_cnt++; tack_cyc = cyc; end
    if (mret_ack) begin mack_cnt++; mack_cyc = cyc; end
    if (redir_valid) begin redir_cnt++; redir_cyc = cyc; redir_pc = redir_pc_w; nv_pc = nv_redir_pc; end
    if (bus.en_except) en_cnt++;
    if (bus.csr_we && bus.csr_re) both_cnt++;
    if (!bus.csr_we && !bus.csr_re && (bus.csr_addr != 0 || bus.csr_wdata != 0)) leak_cnt++;
    if (trap_ack && mret_ack) dual_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_target(input logic [31:0] mtvec, input logic [31:0] cause, input bit vec);
    logic [31:0] base;
    base = mtvec - (mtvec % 4);
    if (vec && (mtvec % 4) == 1 && cause >= 32'h8000_0000) return base + cause * 4;
    return base;
  endfunction

  function automatic logic [31:0] exp_trap_mstatus(input logic [31:0] ms);
    return (ms & ~32'h1888) | (((ms >> 3) & 1) << 7) | ({30'b0, MPP} << 11);
  endfunction

  function automatic logic [31:0] exp_mret_mstatus(input logic [31:0] ms);
    return (ms & ~32'h1888) | (((ms >> 7) & 1) << 3) | 32'h80;
  endfunction

  function automatic int ev_count(input int which);
    case (which)
      0: return tack_cnt;
      1: return mack_cnt;
      default: return redir_cnt;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_ev(input int which, output bit ok);
    int c0;
    c0 = ev_count(which);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (ev_count(which) != c0) ok = 1'b1;
    end
  endtask

  task automatic preload(input logic [31:0] mepc, input logic [31:0] ms, input logic [31:0] mtv);
    pl_mepc = mepc; pl_mstatus = ms; pl_mtvec = mtv; pl_go = 1'b1;
    @(posedge clk); #1 pl_go = 1'b0;
  endtask

  task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] ms, input logic [31:0] mtv);
    bit ok;
    int en0, wr0;
    preload(pc ^ 32'h5A5A_0000, ms, mtv);
    en0 = en_cnt; wr0 = wr_cnt;
    trap_cause = cause; trap_pc = pc; trap_req = 1'b1;
    wait_ev(0, ok);
    chk("trap_ack_seen", {31'b0, ok}, 1);
    if (!ok) begin trap_req = 1'b0; return; end
    @(posedge clk); #1 trap_req = 1'b0;
    wait_ev(2, ok);
    chk("trap_redir_seen", {31'b0, ok}, 1);
    if (!ok) return;
    chk("trap_latency", redir_cyc - tack_cyc, 8);
    chk("trap_target", redir_pc, exp_target(mtv, cause, 1'b1));
    chk("trap_target_novec", nv_pc, exp_target(mtv, cause, 1'b0));
    chk("trap_en_except_cycles", en_cnt - en0, 3);
    chk("trap_write_count", wr_cnt - wr0, 3);
    chk("trap_mepc", m_mepc, pc & 32'hFFFF_FFFC);
    chk("trap_mcause", m_mcause, cause);
    chk("trap_mstatus", m_mstatus, exp_trap_mstatus(ms));
    tick();
  endtask

  task automatic do_mret(input logic [31:0] mepc, input logic [31:0] ms);
    bit ok;
    int en0, wr0;
    preload(mepc, ms, $urandom);
    en0 = en_cnt; wr0 = wr_cnt;
    mret_req = 1'b1;
    wait_ev(1, ok);
    chk("mret_ack_seen", {31'b0, ok}, 1);
    if (!ok) begin mret_req = 1'b0; return; end
    @(posedge clk); #1 mret_req = 1'b0;
    wait_ev(2, ok);
    chk("mret_redir_seen", {31'b0, ok}, 1);
    if (!ok) return;
    chk("mret_latency", redir_cyc - mack_cyc, 6);
    chk("mret_target", redir_pc, mepc & 32'hFFFF_FFFC);
    chk("mret_en_except_cycles", en_cnt - en0, 0);
    chk("mret_write_count", wr_cnt - wr0, 1);
    chk("mret_mstatus", m_mstatus, exp_mret_mstatus(ms));
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int mc0;
    rst_i = 1'b1; trap_req = 1'b0; mret_req = 1'b0; trap_cause = 0; trap_pc = 0;
    tick(); tick();
    chk("rst_trap_ack", {31'b0, trap_ack}, 0);
    chk("rst_mret_ack", {31'b0, mret_ack}, 0);
    chk("rst_redir_valid", {31'b0, redir_valid}, 0);
    chk("rst_redir_pc", redir_pc_w, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_we_re", {30'b0, bus.csr_we, bus.csr_re}, 0);
    chk("rst_addr", bus.csr_addr, 0);
    chk("rst_wdata", bus.csr_wdata, 0);
    chk("rst_en_except", {31'b0, bus.en_except}, 0);
    rst_i = 1'b0;
    tick();

    do_trap(32'hB, 32'h100, 32'h8, 32'h1000);
    chk("plan_mstatus_1880", m_mstatus, 32'h1880);
    do_trap(32'h8000_0007, 32'h2222, 32'h0, 32'h1001);
    chk("plan_vec_101c", redir_pc, 32'h101C);
    chk("plan_novec_1000", nv_pc, 32'h1000);
    do_trap(32'h2, 32'h3330, 32'h8, 32'h1001);
    do_mret(32'h106, 32'h1880);
    chk("plan_mret_88", m_mstatus, 32'h88);

    // Both requests together: trap wins, MRET waits until after the trap redirect.
    preload(32'h0, 32'h8, 32'h2000);
    mc0 = mack_cnt;
    trap_cause = 32'h5; trap_pc = 32'h200; trap_req = 1'b1; mret_req = 1'b1;
    wait_ev(0, ok);
    chk("sim_trap_ack", {31'b0, ok}, 1);
    chk("sim_no_mret_ack", mack_cnt - mc0, 0);
    @(posedge clk); #1 trap_req = 1'b0;
    wait_ev(2, ok);
    chk("sim_trap_redir", redir_pc, exp_target(32'h2000, 32'h5, 1'b1));
    chk("sim_mret_held_busy", mack_cnt - mc0, 0);
    wait_ev(1, ok);
    chk("sim_mret_ack_seen", {31'b0, ok}, 1);
    chk("sim_mret_ack_cycle", mack_cyc - redir_cyc, 1);
    @(posedge clk); #1 mret_req = 1'b0;
    wait_ev(2, ok);
    chk("sim_mret_redir", redir_pc, 32'h200);
    chk("sim_mret_mstatus", m_mstatus, 32'h88);
    tick();

    // Reset in the middle of the trap mstatus write.
    preload(32'h0, 32'h8, 32'h3000);
    trap_cause = 32'h3; trap_pc = 32'h404; trap_req = 1'b1;
    wait_ev(0, ok);
    @(posedge clk); #1 trap_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_we", {31'b0, bus.csr_we}, 1);
    chk("pre_rst_addr", bus.csr_addr, 32'h300);
    #1 rst_i = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_we_re", {30'b0, bus.csr_we, bus.csr_re}, 0);
    chk("mid_rst_addr", bus.csr_addr, 0);
    chk("mid_rst_wdata", bus.csr_wdata, 0);
    chk("mid_rst_redir", {31'b0, redir_valid}, 0);
    tick();
    chk("mid_rst_mepc_kept", m_mepc, 32'h404);
    chk("mid_rst_mstatus_unwritten", m_mstatus, 32'h8);
    tick();
    rst_i = 1'b0;
    tick();
    do_trap(32'h3, 32'h404, 32'h8, 32'h3000);

    do_trap(32'h8000_0002, 32'h5000, 32'h1234_5678, 32'hFFFF_FFFD);
    chk("plan_wrap_4", redir_pc, 32'h4);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_trap({$urandom_range(0, 1) == 1, 25'b0, 6'($urandom_range(0, 63))}, $urandom, $urandom,
                ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)));
      else
        do_mret($urandom, $urandom);
    end

    chk("we_re_exclusive", both_cnt, 0);
    chk("idle_bus_zero", leak_cnt, 0);
    chk("single_ack_per_cycle", dual_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
